// File: rtl/freq_gate_counter.sv
// Gated event counter: counts edge strobes over back-to-back windows of
// GATE_CYCLES clocks and latches each window total with a one-cycle valid pulse.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int COUNT_WIDTH = 16,
  parameter int TIMER_WIDTH = $clog2(GATE_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   edge_pulse,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   count_valid,
  output logic                   busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] ACC_MAX    = '1;

  state_t                 state_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [COUNT_WIDTH-1:0] acc_q;
  logic                   acc_ovf_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   overflow_q;
  logic                   valid_q;
  logic                   busy_q;

  // Window total including this cycle's strobe; clamps instead of wrapping.
  logic [COUNT_WIDTH-1:0] acc_d;
  logic                   acc_ovf_d;
  logic                   acc_at_max;
  logic                   last_cycle;

  always_comb begin
    acc_at_max = (acc_q == ACC_MAX);
    acc_ovf_d  = acc_ovf_q | (acc_at_max & edge_pulse);
    acc_d      = (acc_at_max || !edge_pulse) ? acc_q : acc_q + COUNT_WIDTH'(1);
    last_cycle = (timer_q == TIMER_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      acc_q      <= '0;
      acc_ovf_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q   <= '0;
          acc_q     <= '0;
          acc_ovf_q <= 1'b0;
          busy_q    <= 1'b0;
          // The strobe seen on the starting edge is deliberately not counted.
          if (enable) begin
            state_q <= ST_GATE;
            busy_q  <= 1'b1;
          end
        end
        ST_GATE: begin
          if (!enable) begin
            // Abort: partial window discarded, last result held.
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            timer_q   <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
          end else if (last_cycle) begin
            count_q    <= acc_d;
            overflow_q <= acc_ovf_d;
            valid_q    <= 1'b1;
            timer_q    <= '0;
            acc_q      <= '0;
            acc_ovf_q  <= 1'b0;
          end else begin
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            timer_q   <= timer_q + TIMER_WIDTH'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign count_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Randomized bench for freq_gate_counter: one wide instance for window timing,
// one narrow instance for saturation, both checked against window-sum arithmetic.
module tb_freq_gate_counter;

  localparam int GC   = 100;
  localparam int CW   = 16;
  localparam int GC_S = 20;
  localparam int CW_S = 4;
  localparam int MAX_S = (1 << CW_S) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          enable, edge_pulse;
  logic [CW-1:0] count;
  logic          overflow, count_valid, busy;

  logic            en_s, ep_s;
  logic [CW_S-1:0] count_s;
  logic            ovf_s, cv_s, busy_s;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;
  int exp_ovf = 0;

  freq_gate_counter #(.GATE_CYCLES(GC), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .edge_pulse(edge_pulse),
    .count(count), .overflow(overflow), .count_valid(count_valid), .busy(busy)
  );

  freq_gate_counter #(.GATE_CYCLES(GC_S), .COUNT_WIDTH(CW_S)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en_s), .edge_pulse(ep_s),
    .count(count_s), .overflow(ovf_s), .count_valid(cv_s), .busy(busy_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int popcnt(input bit p[GC]);
    int s = 0;
    for (int i = 0; i < GC; i++) s += int'(p[i]);
    return s;
  endfunction

  function automatic int popcnt_s(input bit p[GC_S]);
    int s = 0;
    for (int i = 0; i < GC_S; i++) s += int'(p[i]);
    return s;
  endfunction

  // Drives one full window (enable held high) and records what the DUT showed.
  task automatic drive_window(input bit pat[GC], output int early_cv, output int final_cv,
                              output int busy_low);
    early_cv = 0; final_cv = 0; busy_low = 0;
    enable = 1'b1;
    for (int k = 0; k < GC; k++) begin
      edge_pulse = pat[k];
      tick();
      if (k < GC - 1) early_cv += int'(count_valid);
      else final_cv = int'(count_valid);
      if (busy !== 1'b1) busy_low++;
    end
    edge_pulse = 1'b0;
  endtask

  task automatic drive_window_s(input bit pat[GC_S], output int early_cv, output int final_cv);
    early_cv = 0; final_cv = 0;
    en_s = 1'b1;
    for (int k = 0; k < GC_S; k++) begin
      ep_s = pat[k];
      tick();
      if (k < GC_S - 1) early_cv += int'(cv_s);
      else final_cv = int'(cv_s);
    end
    ep_s = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; edge_pulse = 1'b0; en_s = 1'b0; ep_s = 1'b0;
    tick(); tick();
    vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", count_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (count_s !== '0 || busy_s !== 1'b0) begin miscompares++; $display("FAIL reset_sat: got count=%0d busy=%b expected 0/0", count_s, busy_s); end
    rst_n = 1'b1;
    edge_pulse = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    edge_pulse = 1'b0;
    $display("reset: count=%0d busy=%b", count, busy);
  endtask

  task automatic test_quarter();
    bit pat[GC];
    int phase, early, fin, blow;
    phase = $urandom_range(0, 3);
    for (int k = 0; k < GC; k++) pat[k] = ((k % 4) == phase);
    enable = 1'b1; edge_pulse = 1'b0;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_busy: got %b expected 1", busy); end
    vectors++; if (count_valid !== 1'b0) begin miscompares++; $display("FAIL start_valid: got %b expected 0", count_valid); end
    for (int w = 0; w < 2; w++) begin
      drive_window(pat, early, fin, blow);
      exp_count = 25; exp_ovf = 0;
      vectors++; if (early != 0) begin miscompares++; $display("FAIL quarter_early_valid: got %0d pulses expected 0", early); end
      vectors++; if (fin != 1) begin miscompares++; $display("FAIL quarter_valid_latency: got %0d expected 1", fin); end
      vectors++; if (blow != 0) begin miscompares++; $display("FAIL quarter_busy: got %0d low cycles expected 0", blow); end
      vectors++; if (count !== CW'(exp_count)) begin miscompares++; $display("FAIL quarter_count: got %0d expected %0d", count, exp_count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL quarter_overflow: got %b expected 0", overflow); end
      $display("window quarter phase=%0d: count=%0d ovf=%b", phase, count, overflow);
    end
  endtask

  task automatic test_random_windows();
    bit pat[GC];
    int dens, early, fin, blow;
    for (int w = 0; w < 3; w++) begin
      dens = $urandom_range(0, 100);
      for (int k = 0; k < GC; k++) pat[k] = ($urandom_range(0, 99) < dens);
      exp_count = popcnt(pat); exp_ovf = 0;
      drive_window(pat, early, fin, blow);
      vectors++; if (early != 0 || fin != 1) begin miscompares++; $display("FAIL rand_valid: got early=%0d final=%0d expected 0/1", early, fin); end
      vectors++; if (count !== CW'(exp_count)) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", count, exp_count); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
      $display("window random dens=%0d: count=%0d expected=%0d", dens, count, exp_count);
    end
  endtask

  task automatic test_boundary();
    bit pa[GC];
    bit pb[GC];
    int early, fin, blow;
    pa[GC-1] = 1'b1;
    pb[0] = 1'b1;
    drive_window(pa, early, fin, blow);
    exp_count = 1;
    vectors++; if (count !== CW'(1) || fin != 1) begin miscompares++; $display("FAIL boundary_last: got count=%0d valid=%0d expected 1/1", count, fin); end
    drive_window(pb, early, fin, blow);
    vectors++; if (count !== CW'(1) || fin != 1) begin miscompares++; $display("FAIL boundary_first: got count=%0d valid=%0d expected 1/1", count, fin); end
    $display("window boundary: count=%0d", count);
  endtask

  task automatic test_abort_mid();
    bit p[50];
    bit pat[GC];
    int placed, r, cv_seen, early, fin, blow;
    placed = 0; cv_seen = 0;
    while (placed < 12) begin
      r = $urandom_range(0, 49);
      if (!p[r]) begin p[r] = 1'b1; placed++; end
    end
    enable = 1'b1;
    for (int k = 0; k < 50; k++) begin
      edge_pulse = p[k];
      tick();
      cv_seen += int'(count_valid);
    end
    enable = 1'b0; edge_pulse = 1'(($urandom_range(0, 1)));
    tick();
    cv_seen += int'(count_valid);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (count !== CW'(exp_count)) begin miscompares++; $display("FAIL abort_hold: got %0d expected %0d", count, exp_count); end
    for (int i = 0; i < 5; i++) begin
      edge_pulse = 1'(($urandom_range(0, 1)));
      tick();
      cv_seen += int'(count_valid);
    end
    vectors++; if (cv_seen != 0) begin miscompares++; $display("FAIL abort_valid: got %0d pulses expected 0", cv_seen); end
    vectors++; if (count !== CW'(exp_count) || busy !== 1'b0) begin miscompares++; $display("FAIL idle_hold: got count=%0d busy=%b expected %0d/0", count, busy, exp_count); end
    $display("abort mid: count=%0d held", count);
    enable = 1'b1; edge_pulse = 1'b0;
    tick();
    for (int k = 0; k < GC; k++) pat[k] = ($urandom_range(0, 3) == 0);
    exp_count = popcnt(pat);
    drive_window(pat, early, fin, blow);
    vectors++; if (fin != 1 || early != 0) begin miscompares++; $display("FAIL reenable_valid: got early=%0d final=%0d expected 0/1", early, fin); end
    vectors++; if (count !== CW'(exp_count)) begin miscompares++; $display("FAIL reenable_count: got %0d expected %0d", count, exp_count); end
    $display("window after re-enable: count=%0d expected=%0d", count, exp_count);
  endtask

  task automatic test_abort_terminal();
    int cv_seen;
    cv_seen = 0;
    enable = 1'b1;
    for (int k = 0; k < GC - 1; k++) begin
      edge_pulse = (k % 3 == 0);
      tick();
      cv_seen += int'(count_valid);
    end
    enable = 1'b0; edge_pulse = 1'b1;
    tick();
    cv_seen += int'(count_valid);
    vectors++; if (cv_seen != 0) begin miscompares++; $display("FAIL term_abort_valid: got %0d pulses expected 0", cv_seen); end
    vectors++; if (count !== CW'(exp_count) || busy !== 1'b0) begin miscompares++; $display("FAIL term_abort_hold: got count=%0d busy=%b expected %0d/0", count, busy, exp_count); end
    edge_pulse = 1'b0;
    $display("abort terminal: count=%0d held", count);
  endtask

  task automatic test_start_pulse();
    bit pat[GC];
    int placed, r, early, fin, blow;
    placed = 0;
    while (placed < 3) begin
      r = $urandom_range(0, GC - 1);
      if (!pat[r]) begin pat[r] = 1'b1; placed++; end
    end
    enable = 1'b1; edge_pulse = 1'b1;
    tick();
    exp_count = 3;
    drive_window(pat, early, fin, blow);
    vectors++; if (count !== CW'(3) || fin != 1) begin miscompares++; $display("FAIL start_pulse_count: got count=%0d valid=%0d expected 3/1", count, fin); end
    $display("window start pulse: count=%0d", count);
    enable = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    bit pat[GC_S];
    int n, rot, early, fin, e_cnt, e_ovf;
    en_s = 1'b1; ep_s = 1'b0;
    tick();
    for (int w = 0; w < 5; w++) begin
      case (w)
        0: n = GC_S;
        1: n = 0;
        2: n = MAX_S;
        3: n = MAX_S + 1;
        default: n = $urandom_range(0, GC_S);
      endcase
      rot = $urandom_range(0, GC_S - 1);
      for (int i = 0; i < GC_S; i++) pat[(i + rot) % GC_S] = (i < n);
      e_cnt = (popcnt_s(pat) > MAX_S) ? MAX_S : popcnt_s(pat);
      e_ovf = (popcnt_s(pat) > MAX_S) ? 1 : 0;
      drive_window_s(pat, early, fin);
      vectors++; if (early != 0 || fin != 1) begin miscompares++; $display("FAIL sat_valid: got early=%0d final=%0d expected 0/1", early, fin); end
      vectors++; if (count_s !== CW_S'(e_cnt)) begin miscompares++; $display("FAIL sat_count n=%0d: got %0d expected %0d", n, count_s, e_cnt); end
      vectors++; if (ovf_s !== 1'(e_ovf)) begin miscompares++; $display("FAIL sat_overflow n=%0d: got %b expected %0d", n, ovf_s, e_ovf); end
      $display("window sat n=%0d: count=%0d ovf=%b", n, count_s, ovf_s);
    end
    en_s = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bit pat[GC];
    int early, fin, blow;
    enable = 1'b1; edge_pulse = 1'b0;
    tick();
    for (int k = 0; k < 37; k++) begin
      edge_pulse = 1'(($urandom_range(0, 1)));
      tick();
    end
    edge_pulse = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_count = 0; exp_ovf = 0;
    vectors++; if (count !== '0 || overflow !== 1'b0) begin miscompares++; $display("FAIL async_count: got count=%0d ovf=%b expected 0/0", count, overflow); end
    vectors++; if (busy !== 1'b0 || count_valid !== 1'b0) begin miscompares++; $display("FAIL async_busy: got busy=%b valid=%b expected 0/0", busy, count_valid); end
    tick();
    #3 rst_n = 1'b1;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL post_reset_busy: got %b expected 1", busy); end
    for (int k = 0; k < GC; k++) pat[k] = ($urandom_range(0, 1) == 1);
    exp_count = popcnt(pat);
    drive_window(pat, early, fin, blow);
    vectors++; if (early != 0 || fin != 1) begin miscompares++; $display("FAIL post_reset_latency: got early=%0d final=%0d expected 0/1", early, fin); end
    vectors++; if (count !== CW'(exp_count)) begin miscompares++; $display("FAIL post_reset_count: got %0d expected %0d", count, exp_count); end
    $display("window after reset: count=%0d expected=%0d", count, exp_count);
    enable = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_quarter();
    test_random_windows();
    test_boundary();
    test_abort_mid();
    test_abort_terminal();
    test_start_pulse();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
